// File: rtl/sum_verify_source.sv
// rtl/sum_verify_source.sv - buffers a packet, checks its trailer sum and replays it unchanged
// One comparison token is issued per packet; replay drains independently of the token.
module sum_verify_source #(
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [511:0] inp_data,
  input  logic         inp_valid,
  output logic         inp_ready,
  input  logic [63:0]  inp_keep,
  input  logic [5:0]   inp_id,
  input  logic         inp_last,
  output logic [511:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_keep,
  output logic [5:0]   out_id,
  output logic         out_last,
  output logic         comparison_result,
  output logic         comparison_valid,
  input  logic         comparison_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 512 + 64 + 6 + 1;

  typedef enum logic {S_COLLECT, S_RESULT} state_t;

  state_t          state, state_next;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [63:0]     acc, lane_sum;
  logic [511:0]    masked;
  logic            full, wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign wr_en = inp_valid && inp_ready;
  // Head moves into the output register whenever that register is free or being emptied.
  assign rd_en = (count != '0) && (!out_valid || out_ready);

  always_comb begin
    masked   = '0;
    lane_sum = '0;
    for (int i = 0; i < 64; i++) masked[8*i +: 8] = inp_data[8*i +: 8] & {8{inp_keep[i]}};
    for (int l = 0; l < 8; l++) lane_sum = lane_sum + masked[64*l +: 64];
  end

  always_comb begin
    state_next       = state;
    inp_ready        = 1'b0;
    comparison_valid = 1'b0;
    case (state)
      S_COLLECT: begin
        inp_ready = reset && !full;
        if (inp_valid && inp_ready && inp_last) state_next = S_RESULT;
      end
      S_RESULT: begin
        comparison_valid = 1'b1;
        if (comparison_ready) state_next = S_COLLECT;
      end
      default: state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= S_COLLECT;
    else        state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= {inp_data, inp_keep, inp_id, inp_last};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      acc               <= '0;
      comparison_result <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_keep          <= '0;
      out_id            <= '0;
      out_last          <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (inp_last) begin
          comparison_result <= (acc != inp_data[63:0]);
          acc               <= '0;
        end else begin
          acc <= acc + lane_sum;
        end
      end
      if (rd_en) begin
        {out_data, out_keep, out_id, out_last} <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: tb/tb_sum_verify_source.sv
// tb/tb_sum_verify_source.sv - directed bench for sum_verify_source
// Each test task drives its own scenario and checks the replay stream and the token.
module tb_sum_verify_source;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [511:0] inp_data = '0;
  logic         inp_valid = 1'b0;
  logic         inp_ready;
  logic [63:0]  inp_keep = '0;
  logic [5:0]   inp_id = '0;
  logic         inp_last = 1'b0;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_keep;
  logic [5:0]   out_id;
  logic         out_last;
  logic         comparison_result;
  logic         comparison_valid;
  logic         comparison_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [582:0] got_q[$];
  logic [582:0] exp_q[$];

  sum_verify_source #(.DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
    .comparison_result(comparison_result), .comparison_valid(comparison_valid),
    .comparison_ready(comparison_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (reset && out_valid && out_ready) got_q.push_back({out_data, out_keep, out_id, out_last});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [511:0] lanes(input logic [63:0] v);
    return {8{v}};
  endfunction

  function automatic logic [511:0] trailer(input logic [63:0] v);
    return {448'd0, v};
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [5:0] id, input logic last);
    int n;
    inp_data = d; inp_keep = k; inp_id = id; inp_last = last; inp_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!inp_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!inp_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: inp_ready=%b required 1", inp_ready);
      inp_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    exp_q.push_back({d, k, id, last});
  endtask

  task automatic handshake();
    comparison_ready = 1'b1;
    @(posedge clock); #1;
    comparison_ready = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; inp_valid = 1'b0; out_ready = 1'b0; comparison_ready = 1'b0;
    wait_cycles(3);
    total++; if (inp_ready !== 1'b0) begin bad++; $display("FAIL rst_inp_ready got=%b exp=0", inp_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (comparison_valid !== 1'b0) begin bad++; $display("FAIL rst_cmp_valid got=%b exp=0", comparison_valid); end
    total++; if (comparison_result !== 1'b0) begin bad++; $display("FAIL rst_cmp_result got=%b exp=0", comparison_result); end
    total++; if (out_data !== 512'd0 || out_last !== 1'b0) begin bad++; $display("FAIL rst_out_data got=%h last=%b exp=0", out_data, out_last); end
    reset = 1'b1;
    #1;
    total++; if (inp_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", inp_ready); end
    wait_cycles(1);
  endtask

  task automatic test_match(input logic [63:0] sum_field, input logic exp_res, input string name);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    send_beat(lanes(64'd1), '1, 6'd5, 1'b0);
    send_beat(lanes(64'd2), '1, 6'd5, 1'b0);
    total++; if (comparison_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid got=%b exp=0", name, comparison_valid); end
    send_beat(trailer(sum_field), '1, 6'd5, 1'b1);
    inp_valid = 1'b0;
    total++; if (comparison_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", name, comparison_valid); end
    total++; if (comparison_result !== exp_res) begin bad++; $display("FAIL %s_result got=%b exp=%b", name, comparison_result, exp_res); end
    handshake();
    total++; if (comparison_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_drop got=%b exp=0", name, comparison_valid); end
    wait_cycles(6);
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL %s_replay_count got=%0d exp=3", name, got_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL %s_replay_beat%0d got=%h exp=%h", name, i, got_q[i], exp_q[i]); end
      end
      total++; if (got_q[2][0] !== 1'b1 || got_q[1][0] !== 1'b0) begin bad++; $display("FAIL %s_replay_last got=%b%b exp=01", name, got_q[1][0], got_q[2][0]); end
    end
  endtask

  task automatic test_keep_wrap();
    logic [511:0] d;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    d = {{6{64'd7}}, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    send_beat(d, 64'h0000_0000_0000_FFFF, 6'd12, 1'b0);
    send_beat(trailer(64'd1), 64'd0, 6'd12, 1'b1);
    inp_valid = 1'b0;
    total++; if (comparison_valid !== 1'b1) begin bad++; $display("FAIL keep_valid got=%b exp=1", comparison_valid); end
    total++; if (comparison_result !== 1'b0) begin bad++; $display("FAIL keep_result got=%b exp=0", comparison_result); end
    handshake();
    wait_cycles(6);
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL keep_replay_count got=%0d exp=2", got_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL keep_replay_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_beat(lanes(64'(i + 1)), '1, 6'd9, 1'b0);
    send_beat(trailer(64'd960), '1, 6'd9, 1'b1);
    inp_valid = 1'b0;
    total++; if (comparison_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", comparison_valid); end
    total++; if (comparison_result !== 1'b0) begin bad++; $display("FAIL bp_result got=%b exp=0", comparison_result); end
    total++; if (inp_ready !== 1'b0) begin bad++; $display("FAIL bp_inp_ready got=%b exp=0", inp_ready); end
    wait_cycles(5);
    total++; if (out_valid !== 1'b1 || out_data !== lanes(64'd1)) begin bad++; $display("FAIL bp_head_stable got=%b/%h exp=1/%h", out_valid, out_data, lanes(64'd1)); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL bp_no_drain got=%0d exp=0", got_q.size()); end
    handshake();
    total++; if (comparison_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", comparison_valid); end
    out_ready = 1'b1;
    wait_cycles(24);
    total++;
    if (got_q.size() != 16) begin bad++; $display("FAIL bp_replay_count got=%0d exp=16", got_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_replay_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (got_q[15][0] !== 1'b1 || got_q[14][0] !== 1'b0) begin bad++; $display("FAIL bp_replay_last got=%b%b exp=01", got_q[14][0], got_q[15][0]); end
    end
  endtask

  task automatic test_token_hold();
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    send_beat(trailer(64'd3), '1, 6'd2, 1'b1);
    inp_data = trailer(64'd0); inp_keep = '1; inp_id = 6'd3; inp_last = 1'b1; inp_valid = 1'b1;
    total++; if (comparison_result !== 1'b1) begin bad++; $display("FAIL hold_first_result got=%b exp=1", comparison_result); end
    repeat (10) begin
      @(negedge clock);
      total++; if (comparison_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", comparison_valid); end
      total++; if (comparison_result !== 1'b1) begin bad++; $display("FAIL hold_result got=%b exp=1", comparison_result); end
      total++; if (inp_ready !== 1'b0) begin bad++; $display("FAIL hold_inp_ready got=%b exp=0", inp_ready); end
    end
    comparison_ready = 1'b1;
    @(posedge clock); #1;
    comparison_ready = 1'b0;
    total++; if (comparison_valid !== 1'b0) begin bad++; $display("FAIL hold_valid_drop got=%b exp=0", comparison_valid); end
    total++; if (inp_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_after got=%b exp=1", inp_ready); end
    @(posedge clock); #1;
    inp_valid = 1'b0;
    exp_q.push_back({trailer(64'd0), 64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 1'b1});
    total++; if (comparison_valid !== 1'b1 || comparison_result !== 1'b0) begin bad++; $display("FAIL hold_second_token got=%b/%b exp=1/0", comparison_valid, comparison_result); end
    handshake();
    wait_cycles(6);
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL hold_replay_count got=%0d exp=2", got_q.size()); end
    else begin
      total++; if (got_q[1] !== exp_q[1]) begin bad++; $display("FAIL hold_replay_second got=%h exp=%h", got_q[1], exp_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    send_beat(lanes(64'd4), '1, 6'd1, 1'b0);
    send_beat(lanes(64'd4), '1, 6'd1, 1'b0);
    inp_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (comparison_valid !== 1'b0) begin bad++; $display("FAIL mid_cmp_valid got=%b exp=0", comparison_valid); end
    got_q.delete(); exp_q.delete();
    send_beat({384'd0, 64'd9, 64'd0}, '1, 6'd4, 1'b1);
    inp_valid = 1'b0;
    total++; if (comparison_valid !== 1'b1 || comparison_result !== 1'b0) begin bad++; $display("FAIL mid_token got=%b/%b exp=1/0", comparison_valid, comparison_result); end
    handshake();
    wait_cycles(6);
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL mid_replay_count got=%0d exp=1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL mid_replay_beat got=%h exp=%h", got_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_match(64'd24, 1'b0, "match");
    test_match(64'd25, 1'b1, "mismatch");
    test_keep_wrap();
    test_backpressure();
    test_token_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_verify_source.md
# sum_verify_source

Upstream producer for the SHA/sum check gate. It accepts an incoming 512-bit packet stream, buffers every beat in a FIFO, and keeps a 64-bit running sum over all beats except the last. The last beat carries the expected sum in bits [63:0]; the block compares it with the running sum and issues a one-per-packet comparison token (result, valid, ready). It replays the buffered packet unchanged on its output stream, which feeds the gate's data input.

## Interface
- DEPTH, 16: FIFO depth in beats; power of two, at least 2; also the maximum packet length.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- inp_data  in  512  input beat payload.
- inp_valid  in  1  input beat valid.
- inp_ready  out  1  input beat accepted when valid and ready are both high.
- inp_keep  in  64  byte enables; bit i covers data[8i+7:8i].
- inp_id  in  6  stream id, forwarded unchanged.
- inp_last  in  1  final beat of the packet (the trailer carrying the expected sum).
- out_data  out  512  replayed beat.
- out_valid  out  1  replayed beat valid.
- out_ready  in  1  downstream accepts the replayed beat.
- out_keep  out  64  replayed keep.
- out_id  out  6  replayed id.
- out_last  out  1  replayed last.
- comparison_result  out  1  0 = sum matched, 1 = mismatch.
- comparison_valid  out  1  result token valid.
- comparison_ready  in  1  consumer takes the token.

## Operation
- Per-beat lane sum: zero every byte whose keep bit is 0, then add the eight 64-bit lanes modulo 2^64.
- Accumulator (64-bit, wraps modulo 2^64) adds the lane sum of each accepted beat that has inp_last=0.
- On the accepted last beat:
  - expected = inp_data[63:0], ignoring keep.
  - result = (accumulator != expected).
  - The accumulator clears to 0 for the next packet.
- Every accepted beat, including the last, is written to the FIFO as {data, keep, id, last}.
- The FIFO drains on out_valid && out_ready, with no modification.
- FSM state S_COLLECT:
  - inp_ready = !fifo_full.
  - An accepted last beat registers the result and moves to S_RESULT.
- FSM state S_RESULT:
  - comparison_valid = 1 and inp_ready = 0.
  - comparison_result is held stable.
  - comparison_valid && comparison_ready returns the FSM to S_COLLECT.
- FIFO draining is independent of the FSM. A new packet may enter while the previous packet is still replaying.
- A single-beat packet (last on the first beat) compares against an accumulator of 0.
- Contract: a packet is at most DEPTH beats. Longer packets stall with inp_ready low until the FIFO drains; they are not checked by the bench.

## Timing
- Reset (reset == 0 at a clock edge) sets:
  - FSM to S_COLLECT; accumulator, FIFO pointers and count to 0.
  - out_valid = 0, comparison_valid = 0, comparison_result = 0.
  - out_data, out_keep, out_id, out_last = 0.
  - inp_ready = 0 during reset, then 1 on the first cycle after reset releases.
- Reset mid-packet discards the FIFO contents and the partial sum, and drops any pending token.
- The data path is registered. A beat accepted at edge N appears at out_* with out_valid=1 after edge N+1 if the FIFO was empty.
- Throughput is one beat per cycle in each direction. Simultaneous read and write when full is not allowed (inp_ready is low when full). Simultaneous read and write when empty is impossible (the write lands first).
- out_* stays stable while out_valid && !out_ready.
- Full and count are based on the count register. A read in the same cycle does not free a slot until the next cycle.
- comparison_valid rises on the cycle after the last beat is accepted and stays high until its handshake.
- After the token handshake at edge M, inp_ready can be 1 on the cycle after edge M.
- Pointers wrap modulo DEPTH.

## Test plan
- Packet checksum match:
  - Stimulus: 3 beats, keep all ones; beat0 lanes all 1, beat1 lanes all 2, trailer [63:0] = 24; out_ready = 1.
  - Response: comparison_result=0 and comparison_valid=1 on the cycle after the trailer is accepted; 3 beats replayed identically, with out_last on the third.
- Packet checksum mismatch:
  - Stimulus: same packet, trailer = 25.
  - Response: comparison_result=1; data replayed unchanged.
- Keep masking and wrap:
  - Stimulus: beat0 with lane0 = 2^64-1, lane1 = 2 and keep = 0x0000_0000_0000_FFFF; trailer = 1.
  - Response: match (result 0).
- Backpressure and full:
  - Stimulus: DEPTH=16, 16-beat packet, out_ready=0.
  - Response: all 16 beats accepted; inp_ready=0 after the 16th while the token is pending; comparison_ready pulse after 5 cycles, then out_ready=1 drains 16 beats in order with the last flag on beat 16.
- Token hold:
  - Stimulus: comparison_ready=0 for 10 cycles after a result, then a second packet offered.
  - Response: comparison_valid and comparison_result stay stable; inp_ready stays 0 until one cycle after the handshake.
- Reset mid-packet:
  - Stimulus: reset low for 1 cycle after 2 of 4 beats, then a fresh 1-beat packet with trailer 0.
  - Response: out_valid=0 after reset; the fresh packet gives result 0 and only 1 beat is replayed.
